// File: rtl/box_datapath.sv
// box_datapath: bouncing WxH box position plus pixel-scan datapath feeding a VGA adapter
module box_datapath #(
  parameter int W       = 8,
  parameter int H       = 8,
  parameter int STEP    = 1,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int XMAX    = 159,
  parameter int YMAX    = 119
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       init,
  input  logic       move,
  input  logic       wren,
  input  logic [2:0] colour_in,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       finish
);
  logic [7:0] posx, cx, nposx;
  logic [6:0] posy, cy, nposy;
  logic       dirx, diry, ndirx, ndiry, done, last_col, last;
  logic [8:0] xe;
  logic [7:0] ye;
  // widened far-edge sums so the overflow test cannot wrap
  always_comb begin
    xe       = {1'b0, posx} + 9'(W - 1 + STEP);
    ye       = {1'b0, posy} + 8'(H - 1 + STEP);
    ndirx    = dirx ? xe <= 9'(XMAX) : posx < 8'(STEP);
    ndiry    = diry ? ye <= 8'(YMAX) : posy < 7'(STEP);
    nposx    = ndirx ? posx + 8'(STEP) : posx - 8'(STEP);
    nposy    = ndiry ? posy + 7'(STEP) : posy - 7'(STEP);
    last_col = cx == 8'(W - 1);
    last     = last_col && cy == 7'(H - 1);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      posx   <= 8'(START_X);
      posy   <= 7'(START_Y);
      dirx   <= 1'b1;
      diry   <= 1'b1;
      cx     <= '0;
      cy     <= '0;
      done   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else if (init) begin
      posx <= 8'(START_X);
      posy <= 7'(START_Y);
      dirx <= 1'b1;
      diry <= 1'b1;
      cx   <= '0;
      cy   <= '0;
      done <= 1'b0;
      plot <= 1'b0;
    end else if (move) begin
      posx <= nposx;
      posy <= nposy;
      dirx <= ndirx;
      diry <= ndiry;
      cx   <= '0;
      cy   <= '0;
      done <= 1'b0;
      plot <= 1'b0;
    end else if (wren && !done) begin
      x      <= posx + cx;
      y      <= posy + cy;
      colour <= colour_in;
      plot   <= 1'b1;
      cx     <= last_col ? '0 : cx + 8'd1;
      cy     <= last ? '0 : last_col ? cy + 7'd1 : cy;
      done   <= last;
    end else begin
      plot <= 1'b0;
      // here wren implies done was already set, so done simply follows wren
      done <= wren;
    end
  end
  assign finish = done;
endmodule

// File: tb/tb_box_datapath.sv
// tb_box_datapath: directed scenarios plus random stimulus against a behavioural box/scan model
module tb_box_datapath;
  localparam int W = 8, H = 8, N = W * H;
  localparam int XMAX = 159, YMAX = 119, STEP = 1;
  logic clk = 0, resetn = 0, init = 0, move = 0, wren = 0;
  logic [2:0] colour_in = 0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic plot, finish;
  int n_chk = 0, n_fail = 0;
  int mpx, mpy, mk, mox, moy, moc;
  bit mdx, mdy, mdone, mop, mvalid = 0;
  int qx[$], qy[$];
  int first_step, last_step, fin_at, cnt;

  box_datapath dut (.clk(clk), .resetn(resetn), .init(init), .move(move), .wren(wren),
                    .colour_in(colour_in), .x(x), .y(y), .colour(colour), .plot(plot), .finish(finish));

  always #10 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void axis(inout int p, inout bit d, input int sz, input int mx);
    if (d && p + sz - 1 + STEP > mx) begin d = 0; p -= STEP; end
    else if (!d && p < STEP) begin d = 1; p += STEP; end
    else p += d ? STEP : -STEP;
  endfunction

  // model: position as integers, scan as a linear pixel index
  always @(posedge clk) begin
    if (!resetn) begin
      mpx = 0; mpy = 0; mdx = 1; mdy = 1; mk = 0; mdone = 0;
      mox = 0; moy = 0; moc = 0; mop = 0; mvalid = 1;
    end else if (init) begin
      mpx = 0; mpy = 0; mdx = 1; mdy = 1; mk = 0; mdone = 0; mop = 0;
    end else if (move) begin
      axis(mpx, mdx, W, XMAX);
      axis(mpy, mdy, H, YMAX);
      mk = 0; mdone = 0; mop = 0;
    end else if (wren && !mdone) begin
      mox = (mpx + mk % W) % 256;
      moy = (mpy + mk / W) % 128;
      moc = colour_in;
      mop = 1;
      if (mk == N - 1) begin mk = 0; mdone = 1; end
      else mk++;
    end else begin
      mop = 0;
      if (!wren) mdone = 0;
    end
  end

  always @(negedge clk) if (mvalid) begin
    check("x", x, mox);
    check("y", y, moy);
    check("colour", colour, moc);
    check("plot", plot, mop);
    check("finish", finish, mdone);
  end

  task automatic step;
    @(negedge clk);
  endtask

  task automatic scan;
    qx.delete(); qy.delete();
    first_step = -1; last_step = -1; fin_at = -1;
    wren = 1;
    for (int i = 1; i <= 200; i++) begin
      step;
      if (plot) begin
        if (first_step < 0) first_step = i;
        last_step = i;
        qx.push_back(int'(x)); qy.push_back(int'(y));
        if (finish && fin_at < 0) fin_at = qx.size();
      end
      if (finish) break;
    end
    if (qx.size() == 0) begin qx.push_back(-1); qy.push_back(-1); end
  endtask

  task automatic do_moves(input int n);
    wren = 0;
    for (int i = 0; i < n; i++) begin
      move = 1; step; move = 0; step;
    end
  endtask

  task automatic first_px(input string nm, input int ex, input int ey);
    scan;
    check({nm, "_x"}, qx[0], ex);
    check({nm, "_y"}, qy[0], ey);
    wren = 0;
  endtask

  initial begin
    step;
    check("rst_x", x, 0); check("rst_y", y, 0); check("rst_colour", colour, 0);
    check("rst_plot", plot, 0); check("rst_finish", finish, 0);
    resetn = 1; init = 1; step; step; init = 0;
    check("init_plot", plot, 0); check("init_finish", finish, 0);
    // full scan from the start position
    colour_in = 3'b101;
    scan;
    check("s2_count", qx.size(), 64);
    check("s2_first_step", first_step, 1);
    check("s2_last_step", last_step, 64);
    check("s2_p0_x", qx[0], 0); check("s2_p0_y", qy[0], 0);
    check("s2_p8_x", qx[8], 0); check("s2_p8_y", qy[8], 1);
    check("s2_p63_x", qx[63], 7); check("s2_p63_y", qy[63], 7);
    check("s2_fin_at", fin_at, 64);
    step;
    check("s2_hold_plot", plot, 0); check("s2_hold_finish", finish, 1);
    // single move then rescan
    wren = 0; move = 1; step; move = 0;
    check("s3_finish", finish, 0);
    check("s3_mpx", mpx, 1); check("s3_mpy", mpy, 1);
    scan;
    check("s3_p0_x", qx[0], 1); check("s3_p0_y", qy[0], 1);
    check("s3_last_x", qx[qx.size()-1], 8); check("s3_last_y", qy[qy.size()-1], 8);
    wren = 0;
    // bottom and right edge bounces
    init = 1; step; init = 0;
    do_moves(112);
    first_px("s5_bot", 112, 112);
    do_moves(1);
    check("s5_mdy", mdy, 0);
    first_px("s5_bot2", 113, 111);
    do_moves(38);
    check("s4_mpx", mpx, 151); check("s4_mdx", mdx, 1);
    first_px("s4_a", 151, 73);
    do_moves(1); first_px("s4_b", 152, 72);
    do_moves(1); check("s4_mdx2", mdx, 0); first_px("s4_c", 151, 71);
    do_moves(1); first_px("s4_d", 150, 70);
    // top-left corner with both directions decreasing
    init = 1; step; init = 0;
    do_moves(4256);
    check("s5_cx", mpx, 0); check("s5_cy", mpy, 0);
    check("s5_cdx", mdx, 0); check("s5_cdy", mdy, 0);
    do_moves(1);
    check("s5_ndx", mdx, 1); check("s5_ndy", mdy, 1);
    first_px("s5_corner", 1, 1);
    // reset during a scan
    init = 1; step; init = 0;
    wren = 1; cnt = 0;
    for (int i = 0; i < 100 && cnt < 20; i++) begin step; if (plot) cnt++; end
    check("s6_cnt20", cnt, 20);
    resetn = 0; wren = 0; step; resetn = 1;
    check("s6_rst_plot", plot, 0); check("s6_rst_finish", finish, 0);
    init = 1; step; init = 0;
    first_px("s6_restart", 0, 0);
    // interrupted scan resumes at the next pixel
    init = 1; step; init = 0;
    wren = 1; cnt = 0;
    for (int i = 0; i < 100 && cnt < 10; i++) begin step; if (plot) cnt++; end
    wren = 0; step; step; step;
    check("s6_pause_plot", plot, 0);
    scan;
    check("s6_resume_x", qx[0], 2); check("s6_resume_y", qy[0], 1);
    check("s6_resume_cnt", qx.size(), 54);
    wren = 0;
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      resetn = $urandom_range(0, 199) != 0;
      init = $urandom_range(0, 49) == 0;
      move = $urandom_range(0, 19) == 0;
      wren = $urandom_range(0, 9) < 7;
      colour_in = 3'($urandom);
      step;
    end
    resetn = 1; init = 0; move = 0; wren = 0; step;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/box_datapath.md
Name: box_datapath

Overview:
- Datapath that pairs with the VGA drawing control FSM.
- Holds the position and direction of one solid W×H box and updates it on each move pulse, with bounce at the screen edges.
- On request, scans the box pixel by pixel into the VGA adapter: x, y, colour and plot.
- Reports completion of each scan to the FSM on finish, so the FSM can sequence erase → move → draw.

Parameters:
- W, 8, box width in pixels (1..160)
- H, 8, box height in pixels (1..120)
- STEP, 1, pixels moved per move pulse on each axis (1..W)
- START_X, 0, x position loaded on init
- START_Y, 0, y position loaded on init
- XMAX, 159, last valid screen column
- YMAX, 119, last valid screen row

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  synchronous reset, active-low; sampled on posedge clk
- init  in  1  level; reload start position and direction, clear scan
- move  in  1  one-cycle pulse; advance position by one step
- wren  in  1  level; scan request from the FSM
- colour_in  in  3  colour to plot; black during erase
- x  out  8  pixel column to the VGA adapter
- y  out  7  pixel row to the VGA adapter
- colour  out  3  pixel colour to the VGA adapter
- plot  out  1  write-enable to the VGA adapter
- finish  out  1  scan complete

Behaviour:
- All outputs are registered.
- Internal state:
  - posx (8b), posy (7b)
  - dirx, diry (1 = increasing)
  - cx (8b), cy (7b) scan counters
  - done flag, which drives finish
- Reset (resetn=0 at posedge), all synchronous:
  - posx=START_X, posy=START_Y, dirx=diry=1
  - cx=cy=0
  - x=0, y=0, colour=0, plot=0, finish=0
  - Reset mid-scan aborts the scan immediately; no further plot.
- Priority per cycle: reset > init > move > wren.
- init=1:
  - Same loads as reset for posx/posy/dir, cx/cy and done.
  - plot=0.
  - x/y/colour hold.
- move=1:
  - cx=cy=0, done=0, plot=0.
  - X axis:
    - If dirx=1 and posx+W-1+STEP > XMAX: dirx←0, posx←posx-STEP.
    - Else if dirx=0 and posx < STEP: dirx←1, posx←posx+STEP.
    - Else posx←posx±STEP per dirx.
  - Y axis: same rule with posy, H, YMAX, diry.
  - X and Y are independent; a corner hit flips both in the same cycle.
  - Arithmetic is 9-bit (x) / 8-bit (y) unsigned to avoid wrap in the compare.
- wren=1 and done=0 (scan cycle):
  - Next cycle: x←posx+cx, y←posy+cy, colour←colour_in, plot←1.
  - Counters: if cx=W-1 then cx←0, cy←cy+1; else cx←cx+1.
  - On the last pixel (cx=W-1, cy=H-1): cx,cy←0 and done←1.
  - finish therefore rises in the same cycle the last pixel's plot is presented.
- Scan latency:
  - First plot appears 1 cycle after wren first seen.
  - Exactly W×H consecutive plot cycles; finish high on the cycle of plot #W×H.
- wren=1 and done=1:
  - plot=0, counters hold, finish stays 1.
  - This covers the cycle where the FSM has not yet left ERASE/DRAW.
- wren=0 (and no init/move):
  - plot=0, done←0.
  - Counters hold; a scan interrupted by wren=0 resumes where it stopped.
- finish is a level equal to done.
- Position never changes during a scan.

Test Plan:
1. Reset, then posedge with resetn=0 → x=0, y=0, colour=0, plot=0, finish=0. Release, then init=1 for 2 cycles → plot=0, finish=0.
2. Defaults, colour_in=3'b101, wren held high:
   - plot high for 64 consecutive cycles.
   - First pixel (0,0), 9th pixel (0,1), last pixel (7,7).
   - finish=1 on the 64th plot cycle, then plot=0 with finish=1 while wren stays high.
3. After scenario 2, move pulse → finish=0, posx=1, posy=1. Next scan's first pixel (1,1), last pixel (8,8).
4. Right-edge bounce, posx=151, dirx=1:
   - move → posx=152.
   - move → dirx=0, posx=151.
   - move → posx=150.
5. Corner (0,0), dirx=diry=0, STEP=1: move → dirx=diry=1, pos=(1,1). Bottom edge posy=112, diry=1: move → diry=0, posy=111.
6. Reset mid-scan at pixel 20 → next cycle plot=0, finish=0. After init, a new scan starts at (START_X,START_Y). Also: wren dropped at pixel 10 and reasserted → resumes at pixel index 10.
